// File: rtl/csa_pipe.sv
// ---------------------------------------------------------------------------
// csa_pipe
//
// Pipelined carry-skip adder with a valid/ready stream interface and a
// per-beat approximate-carry mode.
//
// The first register stage (stage 0) captures the operands. Each following
// stage s (1..NG) adds carry-skip group s-1 on top of the previous stage, so
// the longest combinational path is a single GROUP_SIZE-bit ripple plus the
// skip mux. Stage NG is the output register. A beat therefore becomes visible
// NG edges after the edge that accepted it.
//
// In approximate mode, the carries into groups 1..APPROX_GROUPS are forced
// to zero. Any discarded carry that was 1 sets the running error bit, so ERR
// reports exactly when SUM/COUT differ from the exact A+B+CIN.
//
// Parameters
//   ADDER_SIZE    : operand/sum width (integer multiple of GROUP_SIZE)
//   GROUP_SIZE    : bits per carry-skip group
//   APPROX_GROUPS : number of approximable inter-group carries (0..NG-1)
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   IN_VALID   in   operand beat valid
//   IN_READY   out  block can accept a beat (combinational from OUT_READY)
//   A, B       in   operands [ADDER_SIZE:1]
//   CIN        in   carry into group 0
//   APPROX_EN  in   approximate mode for this beat
//   OUT_VALID  out  result beat valid
//   OUT_READY  in   consumer accepts the result
//   SUM        out  sum [ADDER_SIZE:1]
//   COUT       out  carry out of the top group
//   ERR        out  result differs from the exact sum
// ---------------------------------------------------------------------------
module csa_pipe #(
  parameter int ADDER_SIZE    = 16,
  parameter int GROUP_SIZE    = 4,
  parameter int APPROX_GROUPS = 0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [ADDER_SIZE:1]   A,
  input  logic [ADDER_SIZE:1]   B,
  input  logic                  CIN,
  input  logic                  APPROX_EN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [ADDER_SIZE:1]   SUM,
  output logic                  COUT,
  output logic                  ERR
);

  localparam int NG = ADDER_SIZE / GROUP_SIZE;

  // Stage registers. Index 0 is the operand capture stage; index NG is the
  // output stage. sum_q[0] and err_q[0] are held at zero so every stage can
  // be computed by the same expression.
  logic                 vld_q [0:NG];
  logic                 cy_q  [0:NG];
  logic                 err_q [0:NG];
  logic [ADDER_SIZE:1]  sum_q [0:NG];
  logic [ADDER_SIZE:1]  a_q   [0:NG-1];
  logic [ADDER_SIZE:1]  b_q   [0:NG-1];
  logic                 apx_q [0:NG-1];

  // Next-state values for stages 1..NG.
  logic                 kill  [1:NG];
  logic [GROUP_SIZE:0]  gres  [1:NG];
  logic                 cy_d  [1:NG];
  logic                 err_d [1:NG];
  logic [ADDER_SIZE:1]  sum_d [1:NG];

  logic en;

  // One carry-skip group: ripple add, then bypass the ripple carry with the
  // incoming carry when every bit propagates. Returns {carry_out, sum}.
  function automatic logic [GROUP_SIZE:0] group_add(
    input logic [GROUP_SIZE-1:0] ga,
    input logic [GROUP_SIZE-1:0] gb,
    input logic                  gc
  );
    logic [GROUP_SIZE:0] ripple;
    logic                skip;
    ripple = {1'b0, ga} + {1'b0, gb} + {{GROUP_SIZE{1'b0}}, gc};
    skip   = &(ga ^ gb);
    return {(skip ? gc : ripple[GROUP_SIZE]), ripple[GROUP_SIZE-1:0]};
  endfunction

  // Whole pipeline advances together; a full output stage that is not being
  // taken stalls every stage, bubbles included.
  assign en        = !vld_q[NG] || OUT_READY;
  assign IN_READY  = en;
  assign OUT_VALID = vld_q[NG];
  assign SUM       = sum_q[NG];
  assign COUT      = cy_q[NG];
  assign ERR       = err_q[NG];

  // Group s-1 is computed from stage s-1. Its carry-in is killed for
  // approximate beats when it is one of the lower approximable groups;
  // a killed carry that was 1 is remembered in the error bit.
  always_comb begin
    for (int s = 1; s <= NG; s++) begin
      kill[s]  = apx_q[s-1] && ((s - 1) >= 1) && ((s - 1) <= APPROX_GROUPS);
      gres[s]  = group_add(a_q[s-1][(s-1)*GROUP_SIZE+1 +: GROUP_SIZE],
                           b_q[s-1][(s-1)*GROUP_SIZE+1 +: GROUP_SIZE],
                           cy_q[s-1] && !kill[s]);
      cy_d[s]  = gres[s][GROUP_SIZE];
      err_d[s] = err_q[s-1] || (kill[s] && cy_q[s-1]);
      sum_d[s] = sum_q[s-1];
      sum_d[s][(s-1)*GROUP_SIZE+1 +: GROUP_SIZE] = gres[s][GROUP_SIZE-1:0];
    end
  end

  // Stage registers. Reset discards every in-flight beat and ignores any
  // beat presented in the same cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s <= NG; s++) begin
        vld_q[s] <= 1'b0;
        cy_q[s]  <= 1'b0;
        err_q[s] <= 1'b0;
        sum_q[s] <= '0;
      end
      for (int s = 0; s < NG; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        apx_q[s] <= 1'b0;
      end
    end else if (en) begin
      vld_q[0] <= IN_VALID;
      cy_q[0]  <= CIN;
      err_q[0] <= 1'b0;
      sum_q[0] <= '0;
      a_q[0]   <= A;
      b_q[0]   <= B;
      apx_q[0] <= APPROX_EN;
      for (int s = 1; s <= NG; s++) begin
        vld_q[s] <= vld_q[s-1];
        cy_q[s]  <= cy_d[s];
        err_q[s] <= err_d[s];
        sum_q[s] <= sum_d[s];
      end
      for (int s = 1; s < NG; s++) begin
        a_q[s]   <= a_q[s-1];
        b_q[s]   <= b_q[s-1];
        apx_q[s] <= apx_q[s-1];
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe.sv
// ---------------------------------------------------------------------------
// tb_csa_pipe
//
// Directed self-checking bench for csa_pipe, 16-bit adder, 4-bit groups,
// two approximable carries. Expected values are worked out by hand next to
// each vector. Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_csa_pipe;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [16:1] A;
  logic [16:1] B;
  logic        CIN;
  logic        APPROX_EN;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [16:1] SUM;
  logic        COUT;
  logic        ERR;

  int errors = 0;
  int checks = 0;

  csa_pipe #(
    .ADDER_SIZE    (16),
    .GROUP_SIZE    (4),
    .APPROX_GROUPS (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .CIN       (CIN),
    .APPROX_EN (APPROX_EN),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .SUM       (SUM),
    .COUT      (COUT),
    .ERR       (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one beat, then count edges until the result shows up.
  // lat = -1 when nothing appears within the bound.
  task automatic send_one(input logic [16:1] a, input logic [16:1] b,
                          input logic c, input logic apx, output int lat);
    IN_VALID  = 1'b1;
    A         = a;
    B         = b;
    CIN       = c;
    APPROX_EN = apx;
    OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (OUT_VALID === 1'b1) break;
    end
    if (OUT_VALID !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b1; A = 16'hFFFF; B = 16'h0001; CIN = 1'b1;
    APPROX_EN = 1'b1; OUT_READY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({OUT_VALID, COUT, ERR, SUM} !== 19'h0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got valid=%b cout=%b err=%b sum=%h expected all zero",
                 OUT_VALID, COUT, ERR, SUM);
      end
    end
    RST = 1'b0;
    IN_VALID = 1'b0;
    #1;
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", IN_READY);
    end
    // The beat held during reset must never come out.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_no_output: got %b expected 0", OUT_VALID);
      end
    end
  endtask

  task automatic test_full_skip();
    int lat;
    // FFFF + 0001 = 1_0000: carry skips through every group.
    send_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL skip_latency: got %0d expected 4", lat); end
    checks++; if (SUM !== 16'h0000) begin errors++; $display("[TB] FAIL skip_sum: got %h expected 0000", SUM); end
    checks++; if (COUT !== 1'b1) begin errors++; $display("[TB] FAIL skip_cout: got %b expected 1", COUT); end
    checks++; if (ERR !== 1'b0) begin errors++; $display("[TB] FAIL skip_err: got %b expected 0", ERR); end
    @(negedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_approx();
    int lat;
    logic [16:1] va [3];
    logic [16:1] vb [3];
    logic        vx [3];
    logic [16:1] es [3];
    logic        ee [3];
    // 00FF+0001 approx: carry into group 1 dropped -> 00F0, err.
    // Same exact -> 0100. 0011+0022 has no carries -> 0033, no err.
    va = '{16'h00FF, 16'h00FF, 16'h0011};
    vb = '{16'h0001, 16'h0001, 16'h0022};
    vx = '{1'b1, 1'b0, 1'b1};
    es = '{16'h00F0, 16'h0100, 16'h0033};
    ee = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send_one(va[i], vb[i], 1'b0, vx[i], lat);
      checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL approx%0d_latency: got %0d expected 4", i, lat); end
      checks++; if (SUM !== es[i]) begin errors++; $display("[TB] FAIL approx%0d_sum: got %h expected %h", i, SUM, es[i]); end
      checks++; if (COUT !== 1'b0) begin errors++; $display("[TB] FAIL approx%0d_cout: got %b expected 0", i, COUT); end
      checks++; if (ERR !== ee[i]) begin errors++; $display("[TB] FAIL approx%0d_err: got %b expected %b", i, ERR, ee[i]); end
      @(negedge CLK);
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back();
    logic [16:1] va [3];
    logic [16:1] vb [3];
    logic        vc [3];
    logic [16:1] es [3];
    logic        ec [3];
    int got;
    va = '{16'h1234, 16'h8000, 16'h0000};
    vb = '{16'h4321, 16'h8000, 16'h0000};
    vc = '{1'b0, 1'b0, 1'b1};
    es = '{16'h5555, 16'h0000, 16'h0001};
    ec = '{1'b0, 1'b1, 1'b0};
    got = 0;
    // Beats accepted on edges 0,1,2 show up in loop cycles 5,6,7.
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (cyc < 3) begin
        IN_VALID = 1'b1; A = va[cyc]; B = vb[cyc]; CIN = vc[cyc];
      end else begin
        IN_VALID = 1'b0;
      end
      APPROX_EN = 1'b0;
      OUT_READY = 1'b1;
      #1;
      checks++;
      if (OUT_VALID !== (cyc >= 5 && cyc <= 7)) begin
        errors++;
        $display("[TB] FAIL b2b_valid_cycle%0d: got %b expected %b", cyc, OUT_VALID, (cyc >= 5 && cyc <= 7));
      end
      if (OUT_VALID === 1'b1 && got < 3) begin
        checks++;
        if ({SUM, COUT, ERR} !== {es[got], ec[got], 1'b0}) begin
          errors++;
          $display("[TB] FAIL b2b_result%0d: got sum=%h cout=%b err=%b expected sum=%h cout=%b err=0",
                   got, SUM, COUT, ERR, es[got], ec[got]);
        end
        got++;
      end
      @(negedge CLK);
    end
    checks++;
    if (got !== 3) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 3", got); end
  endtask

  task automatic test_backpressure();
    logic [16:1] va [6];
    logic [16:1] vb [6];
    logic        vc [6];
    logic        vx [6];
    logic [16:1] es [6];
    logic        ec [6];
    logic        ee [6];
    logic [17:0] held;
    int next_in;
    int got;
    // A5A5+5A5A=FFFF; FFFF+FFFF+1=1_FFFF; 1357+2468=37BF;
    // 00FF+0001 approx=00F0 err; 7FFF+0001=8000;
    // 0F0F+0101+1 approx: g0 carries (dropped, err), g1=0, g2 carry dropped
    // was 0 -> g2=0, g3=0+0+1 -> 1001 (exact would be 1011).
    va = '{16'hA5A5, 16'hFFFF, 16'h1357, 16'h00FF, 16'h7FFF, 16'h0F0F};
    vb = '{16'h5A5A, 16'hFFFF, 16'h2468, 16'h0001, 16'h0001, 16'h0101};
    vc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vx = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    es = '{16'hFFFF, 16'hFFFF, 16'h37BF, 16'h00F0, 16'h8000, 16'h1001};
    ec = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ee = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    next_in = 0;
    got = 0;
    held = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      OUT_READY = !(cyc >= 6 && cyc <= 8);
      if (cyc == 2 || next_in >= 6) begin
        IN_VALID = 1'b0;
      end else begin
        IN_VALID = 1'b1; A = va[next_in]; B = vb[next_in];
        CIN = vc[next_in]; APPROX_EN = vx[next_in];
      end
      #1;
      if (cyc >= 6 && cyc <= 8) begin
        checks++;
        if ({OUT_VALID, IN_READY} !== 2'b10) begin
          errors++;
          $display("[TB] FAIL bp_hold_cycle%0d: got valid=%b in_ready=%b expected valid=1 in_ready=0",
                   cyc, OUT_VALID, IN_READY);
        end
        if (cyc == 6) begin
          held = {SUM, COUT, ERR};
        end else begin
          checks++;
          if ({SUM, COUT, ERR} !== held) begin
            errors++;
            $display("[TB] FAIL bp_stable_cycle%0d: got %h expected %h", cyc, {SUM, COUT, ERR}, held);
          end
        end
      end
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        checks++;
        if ({SUM, COUT, ERR} !== {es[got], ec[got], ee[got]}) begin
          errors++;
          $display("[TB] FAIL bp_result%0d: got sum=%h cout=%b err=%b expected sum=%h cout=%b err=%b",
                   got, SUM, COUT, ERR, es[got], ec[got], ee[got]);
        end
        got++;
      end
      if (IN_VALID === 1'b1 && IN_READY === 1'b1) next_in++;
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    checks++;
    if (got !== 6 || next_in !== 6) begin
      errors++;
      $display("[TB] FAIL bp_count: got results=%0d accepted=%0d expected 6 and 6", got, next_in);
    end
    repeat (6) begin
      @(negedge CLK);
      checks++;
      if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_duplicate: got %b expected 0", OUT_VALID); end
    end
  endtask

  task automatic test_reset_midstream();
    int lat;
    for (int i = 0; i < 3; i++) begin
      IN_VALID = 1'b1; A = 16'h0101 << i; B = 16'h0202; CIN = 1'b0;
      APPROX_EN = 1'b0; OUT_READY = 1'b1;
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (OUT_VALID !== 1'b0) begin errors++; $display("[TB] FAIL midrst_flushed_cycle%0d: got %b expected 0", i, OUT_VALID); end
      @(negedge CLK);
    end
    // 0ABC + 1111 = 1BCD
    send_one(16'h0ABC, 16'h1111, 1'b0, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL midrst_latency: got %0d expected 4", lat); end
    checks++; if (SUM !== 16'h1BCD) begin errors++; $display("[TB] FAIL midrst_sum: got %h expected 1BCD", SUM); end
    checks++; if ({COUT, ERR} !== 2'b00) begin errors++; $display("[TB] FAIL midrst_flags: got %b expected 00", {COUT, ERR}); end
    @(negedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0; CIN = 1'b0;
    APPROX_EN = 1'b0; OUT_READY = 1'b1;
    test_reset();
    test_full_skip();
    test_approx();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

endmodule
